// File: rtl/burst_arbiter_pkg.sv
// burst_arbiter_pkg: shared types and helpers for the burst arbiter.
//   state_t     - controller state encoding (IDLE, BURST, DRAIN)
//   LEN_BITS    - width of a requester's beat-count field
//   len_decode  - beat-count field to beat total (0 means 16)
package burst_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LEN_BITS = 4;

  // An all-zero length field encodes the maximum burst of 2**LEN_BITS beats.
  function automatic logic [LEN_BITS:0] len_decode(input logic [LEN_BITS-1:0] len);
    return (len == '0) ? (LEN_BITS+1)'(1 << LEN_BITS) : {1'b0, len};
  endfunction

endpackage

// File: rtl/burst_arbiter_if.sv
// burst_arbiter_if: requester-side and RAM-side signals of the burst arbiter.
//   req/req_addr/req_len : per-requester burst request, word address, length
//   gnt/rvalid/done      : per-requester one-hot owner, data strobe, end pulse
//   rdata                : read data broadcast to all requesters
//   mem_addr/mem_re      : shared RAM read port
//   mem_rdata            : RAM read data, RD_LAT cycles after mem_re
// Modports: slave = arbiter side, master = requesters + RAM side.
interface burst_arbiter_if
  import burst_arbiter_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]          req;
  logic [NREQ*32-1:0]       req_addr;
  logic [NREQ*LEN_BITS-1:0] req_len;
  logic [NREQ-1:0]          gnt;
  logic [NREQ-1:0]          rvalid;
  logic [31:0]              rdata;
  logic [NREQ-1:0]          done;
  logic [31:0]              mem_addr;
  logic                     mem_re;
  logic [31:0]              mem_rdata;

  modport slave (
    input  req, req_addr, req_len, mem_rdata,
    output gnt, rvalid, rdata, done, mem_addr, mem_re
  );

  modport master (
    output req, req_addr, req_len, mem_rdata,
    input  gnt, rvalid, rdata, done, mem_addr, mem_re
  );
endinterface

// File: rtl/burst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select.
//   req        : request vector
//   last_owner : index of the previous owner; search starts one past it
//   win        : one-hot winner, zero when no request is set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic [NREQ-1:0] win
);

  // Walk from the farthest candidate toward the nearest; the last hit
  // overwrites earlier ones, so the nearest requester after last_owner wins.
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NREQ])
        win = NREQ'(1) << ((int'(last_owner) + k) % NREQ);
    end
  end

endmodule

// File: rtl/burst_arbiter.sv
// burst_arbiter: round-robin arbiter that grants one requester at a time a
// locked read burst on a shared RAM port and returns the data to it.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : burst_arbiter_if.slave (requests, grants, data, RAM port)
// Parameters: NREQ requesters (2..4), RD_LAT RAM read latency (1..2).
module burst_arbiter
  import burst_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  burst_arbiter_if.slave bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state, state_nx;
  logic [NREQ-1:0]     win, gnt_q;
  logic [OW-1:0]       win_idx, owner, last_owner;
  logic [31:0]         base;
  logic [LEN_BITS:0]   len_q;
  logic [LEN_BITS-1:0] beat;
  logic                start, issue, last_beat, fin;

  // Read-return tracking: stage s holds beats issued s cycles ago.
  logic [RD_LAT:1]     vld_pipe, lst_pipe;
  logic [OW-1:0]       own_pipe [1:RD_LAT];

  rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .win        (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = OW'(i);
  end

  assign issue     = (state == BURST);
  assign last_beat = ({1'b0, beat} == len_q - (LEN_BITS+1)'(1));
  assign fin       = vld_pipe[RD_LAT] & lst_pipe[RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          start    = 1'b1;
          state_nx = BURST;
        end
      end
      BURST:   if (last_beat) state_nx = DRAIN;
      DRAIN:   if (fin)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Burst context is captured once at grant; req/req_len are not looked at
  // again until the controller is back in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      base       <= '0;
      len_q      <= '0;
      beat       <= '0;
    end else begin
      if (start) begin
        gnt_q <= win;
        owner <= win_idx;
        base  <= bus.req_addr[int'(win_idx)*32 +: 32];
        len_q <= len_decode(bus.req_len[int'(win_idx)*LEN_BITS +: LEN_BITS]);
        beat  <= '0;
      end else if (issue) begin
        beat  <= beat + LEN_BITS'(1);
      end
      if (state == DRAIN && fin) begin
        gnt_q      <= '0;
        last_owner <= owner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      for (int s = 1; s <= RD_LAT; s++) own_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= issue;
      lst_pipe[1] <= issue & last_beat;
      own_pipe[1] <= owner;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        lst_pipe[s] <= lst_pipe[s-1];
        own_pipe[s] <= own_pipe[s-1];
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.mem_re   = issue;
  // Plain 32-bit add: addresses wrap modulo 2**32.
  assign bus.mem_addr = issue ? base + {{(32-LEN_BITS){1'b0}}, beat} : '0;
  assign bus.rdata    = vld_pipe[RD_LAT] ? bus.mem_rdata : '0;

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign bus.rvalid[i] = vld_pipe[RD_LAT] && (own_pipe[RD_LAT] == OW'(i));
    assign bus.done[i]   = fin && (own_pipe[RD_LAT] == OW'(i));
  end

endmodule

// File: tb/tb_burst_arbiter.sv
// tb_burst_arbiter: self-checking bench for burst_arbiter. A 4-requester
// RD_LAT=1 instance carries most scenarios through a scoreboard of expected
// issues and read returns; a 2-requester RD_LAT=2 instance checks latency.
module tb_burst_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_arbiter_if #(.NREQ(4)) bus ();
  burst_arbiter_if #(.NREQ(2)) bus2 ();

  burst_arbiter #(.NREQ(4), .RD_LAT(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  burst_arbiter #(.NREQ(2), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // RAM models: data word is the bitwise inverse of its address.
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  logic [31:0] m1 = JUNK, m2a = JUNK, m2b = JUNK;
  always @(posedge clk) begin
    m1  <= bus.mem_re  ? ~bus.mem_addr  : JUNK;
    m2a <= bus2.mem_re ? ~bus2.mem_addr : JUNK;
    m2b <= m2a;
  end
  assign bus.mem_rdata  = m1;
  assign bus2.mem_rdata = m2b;

  int vectors = 0;
  int miscompares = 0;

  typedef logic [35:0] iss_t;  // {gnt, mem_addr}
  typedef logic [39:0] rd_t;   // {rvalid, done, rdata}
  iss_t exp_iss[$], obs_iss[$];
  rd_t  exp_rd[$],  obs_rd[$];
  logic [3:0] obs_gnt[$];
  int         obs_gap[$];
  logic [3:0] prev_gnt = '0;
  int         idle_run = 0;

  always @(negedge clk) begin
    if (bus.mem_re) obs_iss.push_back({bus.gnt, bus.mem_addr});
    if (bus.rvalid != 0 || bus.done != 0) obs_rd.push_back({bus.rvalid, bus.done, bus.rdata});
    if (bus.gnt != 0 && prev_gnt == 0) begin
      obs_gnt.push_back(bus.gnt);
      obs_gap.push_back(idle_run);
    end
    idle_run = (bus.gnt == 0) ? idle_run + 1 : 0;
    prev_gnt = bus.gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_sb();
    exp_iss.delete(); obs_iss.delete(); exp_rd.delete(); obs_rd.delete();
    obs_gnt.delete(); obs_gap.delete();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] l);
    bus.req_addr[i*32 +: 32] = a;
    bus.req_len[i*4 +: 4]    = l;
  endtask

  // Expected issues and returns for one burst of n beats by requester o.
  task automatic push_burst(input int o, input logic [31:0] b, input int n);
    logic [3:0]  oh = 4'd1 << o;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = b + 32'(k);
      exp_iss.push_back({oh, a});
      exp_rd.push_back({oh, (k == n-1) ? oh : 4'd0, ~a});
    end
  endtask

  task automatic wait_gnt_set(input string nm);
    int t = 0;
    while (bus.gnt == 0 && t < 60) begin step(); t++; end
    vectors++;
    if (bus.gnt == 0) begin miscompares++; $display("FAIL %s.gnt_timeout got 0 want nonzero", nm); end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (bus.gnt != 0 && t < 100) begin step(); t++; end
    vectors++;
    if (bus.gnt != 0) begin miscompares++; $display("FAIL %s.idle_timeout gnt=%b want 0000", nm, bus.gnt); end
    repeat (3) step();
  endtask

  task automatic test_reset();
    bus.req = 4'b1111; bus.req_addr = '0; bus.req_len = '0;
    bus2.req = 2'b00; bus2.req_addr = '0; bus2.req_len = '0;
    step();
    rst = 1'b0;
    repeat (3) step();
    vectors++;
    if ({bus.gnt, bus.rvalid, bus.done, bus.mem_re} !== 13'd0) begin
      miscompares++; $display("FAIL reset.ctl got %b want 0", {bus.gnt, bus.rvalid, bus.done, bus.mem_re});
    end
    vectors++;
    if ({bus.mem_addr, bus.rdata} !== 64'd0) begin
      miscompares++; $display("FAIL reset.data got %h want 0", {bus.mem_addr, bus.rdata});
    end
    vectors++;
    if ({bus2.gnt, bus2.rvalid, bus2.done, bus2.mem_re, bus2.mem_addr} !== 39'd0) begin
      miscompares++; $display("FAIL reset.dut2 got %h want 0", {bus2.gnt, bus2.rvalid, bus2.done, bus2.mem_re, bus2.mem_addr});
    end
    bus.req = 4'b0000;
    step();
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_burst();
    clear_sb();
    set_req(0, 32'h100, 4'd4);
    push_burst(0, 32'h100, 4);
    bus.req = 4'b0001;
    wait_gnt_set("single");
    vectors++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL single.gnt got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    wait_idle("single");
    vectors++;
    if (obs_iss.size() != exp_iss.size() || obs_rd.size() != exp_rd.size()) begin
      miscompares++; $display("FAIL single.count got %0d/%0d want %0d/%0d", obs_iss.size(), obs_rd.size(), exp_iss.size(), exp_rd.size());
    end
    while (exp_iss.size() > 0 && obs_iss.size() > 0) begin
      iss_t e = exp_iss.pop_front(); iss_t a = obs_iss.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL single.issue got %h want %h", a, e); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e = exp_rd.pop_front(); rd_t a = obs_rd.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL single.read got %h want %h", a, e); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int t = 0;
    rst = 1'b0; step(); rst = 1'b1; step();
    clear_sb();
    for (int i = 0; i < 4; i++) set_req(i, 32'(i) * 32'h1000, 4'd1);
    for (int j = 0; j < 5; j++) push_burst((j == 4) ? 0 : j, ((j == 4) ? 32'd0 : 32'(j) * 32'h1000), 1);
    bus.req = 4'b1111;
    while (obs_gnt.size() < 5 && t < 100) begin step(); t++; end
    bus.req = 4'b0000;
    wait_idle("rr");
    vectors++;
    if (obs_gnt.size() != 5) begin miscompares++; $display("FAIL rr.ngrants got %0d want 5", obs_gnt.size()); end
    for (int j = 0; j < 5 && j < obs_gnt.size(); j++) begin
      vectors++;
      if (obs_gnt[j] !== order[j]) begin miscompares++; $display("FAIL rr.order[%0d] got %b want %b", j, obs_gnt[j], order[j]); end
      if (j > 0) begin
        vectors++;
        if (obs_gap[j] != 1) begin miscompares++; $display("FAIL rr.gap[%0d] got %0d want 1", j, obs_gap[j]); end
      end
    end
    vectors++;
    if (obs_iss.size() != exp_iss.size() || obs_rd.size() != exp_rd.size()) begin
      miscompares++; $display("FAIL rr.count got %0d/%0d want %0d/%0d", obs_iss.size(), obs_rd.size(), exp_iss.size(), exp_rd.size());
    end
    while (exp_iss.size() > 0 && obs_iss.size() > 0) begin
      iss_t e = exp_iss.pop_front(); iss_t a = obs_iss.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL rr.issue got %h want %h", a, e); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e = exp_rd.pop_front(); rd_t a = obs_rd.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL rr.read got %h want %h", a, e); end
    end
  endtask

  task automatic test_wrap();
    clear_sb();
    set_req(2, 32'hFFFF_FFF8, 4'd0);
    push_burst(2, 32'hFFFF_FFF8, 16);
    bus.req = 4'b0100;
    wait_gnt_set("wrap");
    bus.req = 4'b0000;
    wait_idle("wrap");
    vectors++;
    if (obs_iss.size() != 16 || obs_rd.size() != 16) begin
      miscompares++; $display("FAIL wrap.count got %0d/%0d want 16/16", obs_iss.size(), obs_rd.size());
    end
    while (exp_iss.size() > 0 && obs_iss.size() > 0) begin
      iss_t e = exp_iss.pop_front(); iss_t a = obs_iss.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL wrap.issue got %h want %h", a, e); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e = exp_rd.pop_front(); rd_t a = obs_rd.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL wrap.read got %h want %h", a, e); end
    end
  endtask

  task automatic test_lock();
    int t = 0;
    clear_sb();
    set_req(0, 32'h200, 4'd8);
    set_req(1, 32'h300, 4'd2);
    push_burst(0, 32'h200, 8);
    push_burst(1, 32'h300, 2);
    bus.req = 4'b0011;
    wait_gnt_set("lock");
    step();
    // Second beat in flight: drop req0 and shorten its length field.
    bus.req = 4'b0010;
    set_req(0, 32'h200, 4'd1);
    while (bus.gnt !== 4'b0010 && t < 100) begin step(); t++; end
    bus.req = 4'b0000;
    wait_idle("lock");
    vectors++;
    if (obs_gnt.size() != 2 || obs_gnt[0] !== 4'b0001 || obs_gnt[obs_gnt.size()-1] !== 4'b0010) begin
      miscompares++; $display("FAIL lock.grants got n=%0d want 0001 then 0010", obs_gnt.size());
    end
    vectors++;
    if (obs_gap.size() == 2 && obs_gap[1] != 1) begin miscompares++; $display("FAIL lock.gap got %0d want 1", obs_gap[1]); end
    vectors++;
    if (obs_iss.size() != 10 || obs_rd.size() != 10) begin
      miscompares++; $display("FAIL lock.count got %0d/%0d want 10/10", obs_iss.size(), obs_rd.size());
    end
    while (exp_iss.size() > 0 && obs_iss.size() > 0) begin
      iss_t e = exp_iss.pop_front(); iss_t a = obs_iss.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL lock.issue got %h want %h", a, e); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e = exp_rd.pop_front(); rd_t a = obs_rd.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL lock.read got %h want %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    set_req(0, 32'h400, 4'd8);
    exp_iss.push_back({4'b0001, 32'h400});
    exp_iss.push_back({4'b0001, 32'h401});
    exp_rd.push_back({4'b0001, 4'b0000, ~32'h400});
    bus.req = 4'b0001;
    wait_gnt_set("rstmid");
    step();
    @(posedge clk); #2;
    rst = 1'b0;   // lands in the cycle issuing the third beat
    #1;
    vectors++;
    if ({bus.gnt, bus.rvalid, bus.done, bus.mem_re, bus.mem_addr, bus.rdata} !== 77'd0) begin
      miscompares++; $display("FAIL rstmid.async got gnt=%b rv=%b done=%b re=%b", bus.gnt, bus.rvalid, bus.done, bus.mem_re);
    end
    bus.req = 4'b0000;
    @(posedge clk); #1;
    vectors++;
    if ({bus.gnt, bus.rvalid, bus.done, bus.mem_re, bus.mem_addr, bus.rdata} !== 77'd0) begin
      miscompares++; $display("FAIL rstmid.edge got gnt=%b rv=%b done=%b re=%b", bus.gnt, bus.rvalid, bus.done, bus.mem_re);
    end
    step();
    rst = 1'b1;
    set_req(1, 32'h600, 4'd1);
    set_req(2, 32'h700, 4'd1);
    push_burst(1, 32'h600, 1);
    bus.req = 4'b0110;
    wait_gnt_set("rstmid");
    vectors++;
    if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL rstmid.first_gnt got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    wait_idle("rstmid");
    vectors++;
    if (obs_iss.size() != 3 || obs_rd.size() != 2) begin
      miscompares++; $display("FAIL rstmid.count got %0d/%0d want 3/2", obs_iss.size(), obs_rd.size());
    end
    while (exp_iss.size() > 0 && obs_iss.size() > 0) begin
      iss_t e = exp_iss.pop_front(); iss_t a = obs_iss.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL rstmid.issue got %h want %h", a, e); end
    end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e = exp_rd.pop_front(); rd_t a = obs_rd.pop_front();
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL rstmid.read got %h want %h", a, e); end
    end
  endtask

  task automatic test_rd_lat2();
    int t = 0, n_iss = 0, n_rd = 0, drain = 0;
    int iss_cyc[$];
    logic seen = 1'b0;
    bus2.req_addr[31:0] = 32'h500;
    bus2.req_len[3:0]   = 4'd3;
    bus2.req = 2'b01;
    while (t < 40 && !(n_rd >= 3 && bus2.gnt == 0)) begin
      step(); t++;
      if (bus2.gnt != 0 && !seen) begin seen = 1'b1; bus2.req = 2'b00; end
      if (bus2.gnt != 0 && !bus2.mem_re) drain++;
      if (bus2.mem_re) begin
        iss_cyc.push_back(t);
        vectors++;
        if (bus2.mem_addr !== 32'h500 + 32'(n_iss)) begin
          miscompares++; $display("FAIL lat2.addr got %h want %h", bus2.mem_addr, 32'h500 + 32'(n_iss));
        end
        n_iss++;
      end
      if (bus2.rvalid != 0) begin
        int want_t = (iss_cyc.size() > 0) ? iss_cyc.pop_front() + 2 : -1;
        vectors++;
        if (t != want_t) begin miscompares++; $display("FAIL lat2.latency got cycle %0d want %0d", t, want_t); end
        vectors++;
        if ({bus2.rvalid, bus2.done, bus2.rdata} !== {2'b01, (n_rd == 2) ? 2'b01 : 2'b00, ~(32'h500 + 32'(n_rd))}) begin
          miscompares++; $display("FAIL lat2.read got %b/%b/%h want rv=01 beat %0d", bus2.rvalid, bus2.done, bus2.rdata, n_rd);
        end
        n_rd++;
      end
    end
    vectors++;
    if (n_iss != 3 || n_rd != 3) begin miscompares++; $display("FAIL lat2.count got %0d/%0d want 3/3", n_iss, n_rd); end
    vectors++;
    if (drain != 2) begin miscompares++; $display("FAIL lat2.drain got %0d want 2", drain); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wrap();
    test_lock();
    test_reset_mid();
    test_rd_lat2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_arbiter.md
BURST_ARBITER -- requirements
Module: burst_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..4).
REQ-002 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..2).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, NREQ, per-requester burst request level.
REQ-006 SHALL have port req_addr, input, NREQ*32, per-requester word start address, slice i = bits [32i+31:32i].
REQ-007 SHALL have port req_len, input, NREQ*4, per-requester beat count, 0 encodes 16.
REQ-008 SHALL have port gnt, output, NREQ, one-hot owner of the shared port, 0 when idle.
REQ-009 SHALL have port rvalid, output, NREQ, one-hot read-data-valid strobe.
REQ-010 SHALL have port rdata, output, 32, read data broadcast to all requesters.
REQ-011 SHALL have port done, output, NREQ, one-cycle end-of-burst pulse.
REQ-012 SHALL have port mem_addr, output, 32, shared RAM port word address.
REQ-013 SHALL have port mem_re, output, 1, shared RAM port read enable.
REQ-014 SHALL have port mem_rdata, input, 32, RAM data, valid RD_LAT cycles after mem_re.

Function
REQ-015 SHALL implement states IDLE, BURST, DRAIN.
REQ-016 IDLE: on any req bit set, SHALL select a winner round-robin, starting the search at (last_owner+1) mod NREQ, then latch its address and length, set gnt, and enter BURST next cycle.
REQ-017 Arbitration SHALL be locked for the whole burst; req changes during BURST/DRAIN SHALL be ignored, and a dropped req SHALL NOT abort the burst.
REQ-018 BURST: each cycle SHALL assert mem_re with mem_addr = base + beat, beat counting 0..len-1.
REQ-019 Address arithmetic SHALL be 32-bit modulo, so 0xFFFFFFFF+1 wraps to 0.
REQ-020 After the last beat is issued, the block SHALL enter DRAIN and deassert mem_re.
REQ-021 For each issued beat, rvalid[owner] SHALL assert exactly RD_LAT cycles later, with rdata = mem_rdata in the same cycle.
REQ-022 done[owner] SHALL pulse together with the final rvalid.
REQ-023 DRAIN SHALL last until the final rvalid, then go to IDLE with gnt = 0 and last_owner updated.
REQ-024 There SHALL be exactly one idle cycle between consecutive bursts, including back-to-back bursts from the same requester.
REQ-025 Round-robin SHALL guarantee every persistent requester is granted within NREQ bursts.
REQ-026 The latched length SHALL be used; req_len changes after the grant SHALL have no effect.
REQ-027 mem_re SHALL never assert outside BURST; at most one gnt bit and at most one rvalid bit SHALL be high in any cycle.

Reset
REQ-028 While rst = 0, gnt, rvalid, done, mem_re SHALL be 0, mem_addr and rdata SHALL be 0, state SHALL be IDLE, and last_owner SHALL be NREQ-1 so requester 0 wins first.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no done pulse; in-flight read data SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold the state encoding, the LEN_BITS = 4 constant, and the len-0-means-16 decode function.
REQ-031 The round-robin winner selection SHALL be a separate combinational sub-module, rr_pick (inputs: req, last_owner; output: one-hot winner).
REQ-032 The read-latency delay SHALL be a small RD_LAT-deep shift register of valid/owner/last flags inside burst_arbiter.

Verification
REQ-033 req = 0001, addr0 = 0x100, len0 = 4:
- mem_re for 4 cycles at addresses 0x100..0x103
- rvalid[0] for 4 cycles, each RD_LAT after its issue
- done[0] pulses on the 4th rvalid
REQ-034 req = 1111 held continuously, len = 1 each: grants in order 0,1,2,3,0, each separated by one idle cycle.
REQ-035 len = 0, addr = 0xFFFFFFF8: 16 beats issued, addresses wrap 0xFFFFFFFF -> 0x00000000 -> 0x00000007.
REQ-036 req0 dropped and req_len0 changed in the 2nd beat of a len-8 burst: all 8 beats complete, done[0] pulses, then req1 is served.
REQ-037 rst pulsed low during beat 3 of 8:
- all outputs 0 on the next edge
- no done pulse
- first grant after reset goes to the lowest active requester
REQ-038 RD_LAT = 2 build, len = 3: rvalid appears 2 cycles after each mem_re, and DRAIN lasts 2 cycles.
